// File: rtl/sim_char_uart.sv
`default_nettype none
// ============================================================================
// Module      : sim_char_uart
// Description : Symbol capture and UART bridge. It qualifies the machine's
//               active-low symbol strobe SIMn and captures the four output
//               nibbles as one 16-bit word. Words are buffered in a small
//               FIFO and sent to the host as two 8N1 bytes, high byte first.
//
// Parameters  : CLK_DIV  - xtal_clk cycles per UART bit (4..65535)
//               FIFO_AW  - FIFO address width, depth = 2**FIFO_AW words
//               MIN_LOW  - synchronized low cycles that qualify a strobe
//
// Ports       : xtal_clk           in   system clock
//               init_n             in   asynchronous active-low reset
//               SIMn               in   symbol strobe, active low, async
//               X3n/Y3n/X2n/Y2n    in   machine output nibbles, active low
//               txd                out  UART serial output, idle high
//               busy               out  frame in progress
//               overflow           out  sticky, strobe found FIFO full
//               fifo_level         out  words currently buffered
//
// Revision    : 1.0 - initial release
// ============================================================================
module sim_char_uart #(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 3,
    parameter int MIN_LOW = 4
) (
    input  logic               xtal_clk,
    input  logic               init_n,
    input  logic               SIMn,
    input  logic [3:0]         X3n,
    input  logic [3:0]         Y3n,
    input  logic [3:0]         X2n,
    input  logic [3:0]         Y2n,
    output logic               txd,
    output logic               busy,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int                 c_DEPTH    = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   c_DEPTH_L  = (FIFO_AW + 1)'(c_DEPTH);
    localparam logic [FIFO_AW:0]   c_LVL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] c_PTR_ONE  = FIFO_AW'(1);
    localparam logic [15:0]        c_DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [7:0]         c_LOW_MAX  = 8'(MIN_LOW);
    localparam logic [7:0]         c_LOW_TGT  = 8'(MIN_LOW - 1);

    // ------------------------------------------------------------------
    // Input synchronizers. Data is inverted on entry so the synchronized
    // bus already holds the active-high capture word {X3,Y3,X2,Y2}.
    // SIMn chain resets high so a reset never looks like a strobe.
    // ------------------------------------------------------------------
    logic        r_simn_meta;
    logic        r_simn_sync;
    logic [15:0] r_data_meta;
    logic [15:0] r_data_sync;

    always_ff @(posedge xtal_clk or negedge init_n) begin
        if (!init_n) begin
            r_simn_meta <= 1'b1;
            r_simn_sync <= 1'b1;
            r_data_meta <= '0;
            r_data_sync <= '0;
        end else begin
            r_simn_meta <= SIMn;
            r_simn_sync <= r_simn_meta;
            r_data_meta <= ~{X3n, Y3n, X2n, Y2n};
            r_data_sync <= r_data_meta;
        end
    end

    // ------------------------------------------------------------------
    // Strobe qualification. The counter saturates at MIN_LOW, so the
    // MIN_LOW-1 -> MIN_LOW step happens once per low period; that step
    // is registered as the single event pulse.
    // ------------------------------------------------------------------
    logic [7:0] r_low_cnt;
    logic       r_event;

    always_ff @(posedge xtal_clk or negedge init_n) begin
        if (!init_n) begin
            r_low_cnt <= '0;
            r_event   <= 1'b0;
        end else begin
            if (r_simn_sync) begin
                r_low_cnt <= '0;
            end else if (r_low_cnt != c_LOW_MAX) begin
                r_low_cnt <= r_low_cnt + 8'd1;
            end
            r_event <= !r_simn_sync && (r_low_cnt == c_LOW_TGT);
        end
    end

    // ------------------------------------------------------------------
    // FIFO. A pop in the same cycle frees the slot being written, so a
    // push into a full FIFO is accepted when a pop coincides.
    // ------------------------------------------------------------------
    logic [15:0]        r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic               r_overflow;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [15:0]        w_head;

    assign w_full  = (r_level == c_DEPTH_L);
    assign w_empty = (r_level == '0);
    assign w_push  = r_event && (!w_full || w_pop);
    assign w_drop  = r_event && w_full && !w_pop;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge xtal_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_data_sync;
        end
    end

    always_ff @(posedge xtal_clk or negedge init_n) begin
        if (!init_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_word;
    logic [6:0]  r_shift;
    logic [15:0] r_baud;
    logic [2:0]  r_bit_idx;
    logic        r_byte_idx;
    logic        r_txd;
    logic        r_busy;
    logic        w_baud_end;
    logic [7:0]  w_cur_byte;

    assign w_baud_end = (r_baud == c_DIV_LAST);
    assign w_cur_byte = r_byte_idx ? r_word[7:0] : r_word[15:8];

    // The end of the second stop bit pops the next word directly so that
    // consecutive words run back to back without an idle cycle.
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) ||
                    ((r_state == ST_STOP) && w_baud_end && r_byte_idx));

    always_ff @(posedge xtal_clk or negedge init_n) begin
        if (!init_n) begin
            r_state    <= ST_IDLE;
            r_word     <= '0;
            r_shift    <= '0;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= 1'b0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_word     <= w_head;
                        r_byte_idx <= 1'b0;
                        r_baud     <= '0;
                        r_txd      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_txd     <= w_cur_byte[0];
                        r_shift   <= w_cur_byte[7:1];
                        r_state   <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_txd     <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[6:1]};
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (!r_byte_idx) begin
                            r_byte_idx <= 1'b1;
                            r_txd      <= 1'b0;
                            r_state    <= ST_START;
                        end else if (w_pop) begin
                            r_word     <= w_head;
                            r_byte_idx <= 1'b0;
                            r_txd      <= 1'b0;
                            r_state    <= ST_START;
                        end else begin
                            r_txd   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign txd        = r_txd;
    assign busy       = r_busy;
    assign overflow   = r_overflow;
    assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_sim_char_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_sim_char_uart
// Description : Self-checking bench for sim_char_uart. A behavioural model
//               (word queue plus frame-position arithmetic) predicts txd,
//               busy, overflow and fifo_level every cycle; directed literal
//               checks pin the model on the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_char_uart;

    localparam int D     = 8;
    localparam int AW    = 3;
    localparam int ML    = 4;
    localparam int DEPTH = 8;

    logic        xtal_clk = 1'b0;
    logic        init_n   = 1'b0;
    logic        SIMn     = 1'b1;
    logic [3:0]  X3n      = 4'hF;
    logic [3:0]  Y3n      = 4'hF;
    logic [3:0]  X2n      = 4'hF;
    logic [3:0]  Y2n      = 4'hF;
    logic        txd;
    logic        busy;
    logic        overflow;
    logic [AW:0] fifo_level;

    int vectors     = 0;
    int miscompares = 0;

    sim_char_uart #(
        .CLK_DIV (D),
        .FIFO_AW (AW),
        .MIN_LOW (ML)
    ) dut (
        .xtal_clk   (xtal_clk),
        .init_n     (init_n),
        .SIMn       (SIMn),
        .X3n        (X3n),
        .Y3n        (Y3n),
        .X2n        (X2n),
        .Y2n        (Y2n),
        .txd        (txd),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 xtal_clk = ~xtal_clk;

    // ------------------------------------------------------------------
    // Behavioural model. lowrun[i] = length of the raw low run ending at
    // the sample taken i edges ago; a word is pushed at edge n when the
    // run ending at sample n-3 is exactly MIN_LOW long, with the data of
    // sample n-2. The transmitter is a frame start time plus a word.
    // ------------------------------------------------------------------
    longint      cyc = 0;
    int          lowrun [4];
    logic [15:0] dh [3];
    logic [15:0] q [$];
    bit          m_active = 1'b0;
    longint      m_start  = 0;
    logic [15:0] m_word   = '0;
    bit          m_ovf    = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) lowrun[i] = 0;
        for (int i = 0; i < 3; i++) dh[i] = '0;
        q.delete();
        m_active = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_step();
        bit push;
        cyc = cyc + 1;
        for (int i = 3; i > 0; i--) lowrun[i] = lowrun[i-1];
        lowrun[0] = SIMn ? 0 : ((lowrun[1] > 100000) ? lowrun[1] : lowrun[1] + 1);
        dh[2] = dh[1];
        dh[1] = dh[0];
        dh[0] = ~{X3n, Y3n, X2n, Y2n};
        push = (lowrun[3] == ML);
        if (m_active && (cyc - m_start == 20 * D)) begin
            if (q.size() > 0) begin
                m_word  = q.pop_front();
                m_start = cyc;
            end else begin
                m_active = 1'b0;
            end
        end else if (!m_active && q.size() > 0) begin
            m_word   = q.pop_front();
            m_start  = cyc;
            m_active = 1'b1;
        end
        if (push) begin
            if (q.size() < DEPTH) q.push_back(dh[2]);
            else m_ovf = 1'b1;
        end
    endtask

    always @(posedge xtal_clk or negedge init_n) begin
        if (!init_n) model_reset();
        else         model_step();
    end

    function automatic logic exp_txd();
        int p;
        if (!m_active) return 1'b1;
        p = int'((cyc - m_start) / D);
        if (p == 0 || p == 10) return 1'b0;
        if (p == 9 || p == 19) return 1'b1;
        if (p < 9) return m_word[8 + p - 1];
        return m_word[p - 11];
    endfunction

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    bit prev_busy = 1'b0;
    int rises     = 0;

    always @(negedge xtal_clk) begin
        logic            e_txd;
        logic [AW:0]     e_lvl;
        e_txd = exp_txd();
        e_lvl = (AW + 1)'(q.size());
        vectors++;
        if (txd !== e_txd || busy !== m_active || fifo_level !== e_lvl || overflow !== m_ovf) begin
            miscompares++;
            $display("FAIL model cyc=%0d: txd=%b/%b busy=%b/%b level=%0d/%0d ovf=%b/%b (got/exp)",
                     cyc, txd, e_txd, busy, m_active, fifo_level, e_lvl, overflow, m_ovf);
        end
        if (busy === 1'b1 && !prev_busy) rises++;
        prev_busy = (busy === 1'b1);
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_word(input logic [15:0] w);
        {X3n, Y3n, X2n, Y2n} = ~w;
    endtask

    task automatic strobe(input logic [15:0] w, input int low, input int high);
        set_word(w);
        SIMn = 1'b0;
        repeat (low) @(negedge xtal_clk);
        SIMn = 1'b1;
        repeat (high) @(negedge xtal_clk);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        repeat (10) @(negedge xtal_clk);
        while ((busy !== 1'b0 || fifo_level !== '0) && n < budget) begin
            @(negedge xtal_clk);
            n++;
        end
        chk(name, (busy !== 1'b0 || fifo_level !== '0) ? 1 : 0, 0);
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [19:0] pat;
        logic        bits [161];
        int          n;
        int          bcount;
        int          r0;
        longint      e_edge;
        longint      k;

        repeat (3) @(negedge xtal_clk);
        chk("reset_txd", txd, 1);
        chk("reset_busy", busy, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_level", fifo_level, 0);
        init_n = 1'b1;
        repeat (5) @(negedge xtal_clk);

        // Single word 16'h1248: start,0x12,stop,start,0x48,stop
        pat = 20'b10100100001000100100;
        set_word(16'h1248);
        SIMn = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 40) begin
            @(negedge xtal_clk);
            n++;
        end
        chk("single_busy_rise", busy, 1);
        bcount = 0;
        for (int t = 0; t <= 160; t++) begin
            if (t > 0) @(negedge xtal_clk);
            if (t == 2) SIMn = 1'b1;
            bits[t] = txd;
            if (busy === 1'b1) bcount++;
        end
        for (int i = 0; i < 20; i++) chk($sformatf("single_bit%0d", i), bits[i * D + D / 2], pat[i]);
        chk("single_busy_cycles", bcount, 160);
        chk("single_level_end", fifo_level, 0);

        // Glitch rejection
        r0 = rises;
        repeat (5) strobe(16'h5A5A, 3, 3);
        repeat (10) @(negedge xtal_clk);
        chk("glitch_level", fifo_level, 0);
        chk("glitch_txd", txd, 1);
        chk("glitch_frames", rises - r0, 0);

        // Long strobe
        r0 = rises;
        strobe(16'hC0DE, 1000, 10);
        wait_idle(400, "long_drain");
        chk("long_frames", rises - r0, 1);

        // Push/pop collision on a full FIFO
        for (int i = 0; i < 9; i++) strobe(16'h0100 + 16'(i), 6, 6);
        chk("coll_fill_level", fifo_level, 8);
        e_edge = m_start + 20 * D;
        k = e_edge - 2 - ML;
        while (cyc < k - 1) @(negedge xtal_clk);
        set_word(16'hBEEF);
        SIMn = 1'b0;
        repeat (3 + ML) @(negedge xtal_clk);
        chk("coll_edge", cyc, e_edge);
        chk("coll_level", fifo_level, 8);
        chk("coll_ovf", overflow, 0);
        SIMn = 1'b1;
        wait_idle(10 * 20 * D, "coll_drain");
        chk("coll_ovf_end", overflow, 0);

        // Overflow: 10 strobes, data = index
        for (int i = 0; i < 10; i++) strobe(16'(i) * 16'h1111, 6, 6);
        repeat (2) @(negedge xtal_clk);
        chk("ovf_flag", overflow, 1);
        chk("ovf_level", fifo_level, 8);
        wait_idle(10 * 20 * D, "ovf_drain");
        chk("ovf_sticky", overflow, 1);

        // Reset during DATA of byte 0
        set_word(16'h00FF);
        SIMn = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 40) begin
            @(negedge xtal_clk);
            n++;
        end
        SIMn = 1'b1;
        repeat (D + 3) @(negedge xtal_clk);
        chk("rst_pre_txd", txd, 0);
        #2 init_n = 1'b0;
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        repeat (3) @(negedge xtal_clk);
        init_n = 1'b1;
        repeat (3) @(negedge xtal_clk);
        r0 = rises;
        strobe(16'hA55A, 6, 6);
        wait_idle(400, "rst_after_drain");
        chk("rst_after_frames", rises - r0, 1);

        // Randomized strobes
        for (int i = 0; i < 40; i++) begin
            int lo;
            int hi;
            lo = int'($urandom_range(1, 10));
            hi = int'($urandom_range(1, 40));
            if ($urandom_range(0, 7) == 0) hi += 200;
            strobe(16'($urandom), lo, hi);
        end
        wait_idle(2 * DEPTH * 20 * D, "rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sim_char_uart.md
# sim_char_uart

Downstream capture stage for the machine's symbol output. It watches the symbol strobe SIMn and samples the four output nibbles X3n/Y3n/X2n/Y2n on each qualified strobe. Each 16-bit word is buffered in a FIFO and serialized to a host as two 8N1 UART bytes. It sits between the `machine` outputs and a board-level TX pin, replacing the original printer/indicator consumer.

## Interface
- CLK_DIV, 434: xtal_clk cycles per UART bit; legal range 4..65535.
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW words (8 at default).
- MIN_LOW, 4: consecutive synchronized-low cycles of SIMn needed to qualify a strobe; legal range 1..255.
- xtal_clk  in  1  system clock, same net as the machine clock.
- init_n  in  1  asynchronous, active-low reset.
- SIMn  in  1  symbol strobe from machine, active low, asynchronous to xtal_clk.
- X3n, Y3n, X2n, Y2n  in  4 each  machine output nibbles, active low.
- txd  out  1  UART serial output, idle high.
- busy  out  1  high while a frame is being shifted out.
- overflow  out  1  sticky; set when a qualified strobe finds the FIFO full.
- fifo_level  out  FIFO_AW+1  words currently held in the FIFO.

## Operation
- Synchronization: SIMn and all 16 data bits pass through a 2-FF synchronizer.
- Qualification: a low counter runs while synchronized SIMn = 0, saturating at MIN_LOW, and clears when SIMn = 1.
  - A strobe event fires once, in the cycle the counter reaches MIN_LOW.
  - SIMn held low indefinitely yields exactly one event.
  - SIMn must return high for at least 1 synchronized cycle before the next event can fire.
  - Low pulses shorter than MIN_LOW cycles are ignored.
- Capture word W = {~X3n, ~Y3n, ~X2n, ~Y2n} (MSB to LSB), taken from the synchronized data in the event cycle.
  - The machine holds the nibbles stable for the whole SIMn low period.
- FIFO: a circular buffer of 2**FIFO_AW words.
  - Push on an event when not full.
  - On an event when full: drop W and set overflow. overflow clears only on reset.
  - Push and pop in the same cycle are both honoured, even when the FIFO is full. fifo_level is unchanged and no overflow is raised.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the word into a 16-bit shift holder, set byte index = 0, go to START.
  - START: txd = 0 for CLK_DIV cycles, then DATA.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each.
    - Byte 0 = W[15:8] (X3, Y3).
    - Byte 1 = W[7:0] (X2, Y2).
  - STOP: txd = 1 for CLK_DIV cycles.
    - Byte index = 0: go to START for byte 1.
    - Otherwise: go to IDLE.
  - IDLE with an empty FIFO holds txd = 1.
- busy = 1 in every state except IDLE.
- Reset values: txd = 1, busy = 0, overflow = 0, fifo_level = 0, FSM = IDLE, all counters and pointers 0.
- Reset mid-operation aborts the frame: txd returns high asynchronously and the FIFO contents are discarded.

## Timing
- Strobe latency: if SIMn is first sampled low at rising edge k and stays low, the event fires in the cycle after edge k+1+MIN_LOW. The word is written at edge k+2+MIN_LOW, and fifo_level increments at that edge.
- Pop latency: the FIFO-to-TX pop occurs on the first edge where the FSM is in IDLE and fifo_level > 0. txd falls at that same edge (entry to START).
- Frame length: 20 × CLK_DIV cycles per word (two bytes of 10 bits). Back-to-back words have no idle gap between the STOP of byte 1 and the next START.
- Baud counter: counts 0..CLK_DIV−1 and reloads at 0 on every state or bit transition. Bit boundaries are exact, with no cumulative drift.
- fifo_level reflects a pop at the pop edge and a push at the push edge.

## Test plan
- Single word: CLK_DIV = 8, MIN_LOW = 4; X3n=4'hE, Y3n=4'hD, X2n=4'hB, Y2n=4'h7, SIMn low 10 cycles -> one word 16'h1248. txd emits start, 0x12 LSB-first, stop, start, 0x48, stop; 160 cycles with busy high; fifo_level returns to 0.
- Glitch rejection: SIMn low for 3 synchronized cycles (MIN_LOW = 4), repeated 5 times -> fifo_level stays 0 and txd stays 1.
- Long strobe: SIMn held low 1000 cycles -> exactly one word transmitted.
- Overflow: CLK_DIV = 1000; 10 qualified strobes spaced 20 cycles apart, data = strobe index.
  - 1st word is popped immediately and 8 are buffered, so the 10th is dropped and overflow = 1.
  - Transmitted sequence is indices 0..8.
- Push/pop collision: FIFO full, qualified strobe timed to the pop edge -> fifo_level stays at 8, overflow stays 0, and the new word is transmitted last.
- Reset mid-frame: assert init_n low during DATA of byte 0 -> txd = 1 immediately, busy = 0, fifo_level = 0, overflow = 0. After release, a new strobe transmits normally.
